// File: rtl/interboard_pkg.sv
// -----------------------------------------------------------------------------
// interboard_pkg
// Shared definitions for the interboard message link between two Bingo boards:
// default message field widths, game message type codes, FSM state encodings
// and the helper that derives how many wire beats one message needs.
// -----------------------------------------------------------------------------
package interboard_pkg;

  localparam int TYPE_W_DEF = 3;
  localparam int NUM_W_DEF  = 5;

  // Game message types carried in the type field.
  typedef enum logic [TYPE_W_DEF-1:0] {
    MSG_RST    = 3'd0,
    MSG_SELECT = 3'd1,
    MSG_GUESS  = 3'd2,
    MSG_WIN    = 3'd3,
    MSG_CALL   = 3'd4,
    MSG_SCORE  = 3'd5
  } msg_type_e;

  // Type that makes the receiver raise rx_rst alongside rx_en.
  localparam logic [TYPE_W_DEF-1:0] RST_TYPE_DEF = MSG_RST;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_REL
  } tx_state_e;

  typedef enum logic {
    R_IDLE,
    R_ACK
  } rx_state_e;

  // Number of LINK_W-wide beats needed to carry msg_w bits (ceiling divide).
  function automatic int beats(input int msg_w, input int link_w);
    return (msg_w + link_w - 1) / link_w;
  endfunction

endpackage

// File: rtl/interboard_link_if.sv
// -----------------------------------------------------------------------------
// interboard_link_if
// Board-pin bundle of the 4-phase req/ack link.
//   req_out/ack_out/data_out : driven by this board towards the peer
//   req_in/ack_in/data_in    : arriving from the peer (req/ack asynchronous)
// Modports:
//   master : the interboard_link block
//   slave  : whatever sits on the pin side (peer model, loopback, pads)
// -----------------------------------------------------------------------------
interface interboard_link_if #(
  parameter int LINK_W = 6
);
  logic              req_out;
  logic              ack_out;
  logic [LINK_W-1:0] data_out;
  logic              req_in;
  logic              ack_in;
  logic [LINK_W-1:0] data_in;

  modport master (
    output req_out, ack_out, data_out,
    input  req_in, ack_in, data_in
  );

  modport slave (
    input  req_out, ack_out, data_out,
    output req_in, ack_in, data_in
  );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO holding outgoing messages.
//   clk, rst        : clock, asynchronous active-low reset
//   wr_en, wr_data  : push (ignored while full)
//   rd_en, rd_data  : pop (ignored while empty); rd_data shows the head entry
//   full, empty     : occupancy flags, combinational from the entry count
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // and count define which entries are valid, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register sees the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/interboard_link.sv
// -----------------------------------------------------------------------------
// interboard_link
// Carries typed game messages {type, num} to a peer board over a 4-phase
// req/ack link whose data bus may be narrower than a message (multi-beat).
//   clk, rst             : system clock, asynchronous active-low reset
//   tx_en/tx_type/tx_num : enqueue one message into the TX FIFO
//   tx_ready             : FIFO not full
//   tx_overflow          : 1-cycle pulse, an enqueue was dropped (FIFO full)
//   tx_timeout           : 1-cycle pulse, sender abandoned the current message
//   link_busy            : sender active or messages still queued
//   link (master)        : board pins, req/ack in each direction plus data
//   rx_en                : 1-cycle pulse, a complete message was received
//   rx_type/rx_num       : last received message, held until the next rx_en
//   rx_rst               : pulses with rx_en when rx_type equals RST_TYPE
// Sender and receiver run independently, so both directions may be active.
// -----------------------------------------------------------------------------
module interboard_link
  import interboard_pkg::*;
#(
  parameter int                TYPE_W     = TYPE_W_DEF,
  parameter int                NUM_W      = NUM_W_DEF,
  parameter int                LINK_W     = 6,
  parameter int                FIFO_DEPTH = 4,
  parameter int                TIMEOUT    = 50000,
  parameter logic [TYPE_W-1:0] RST_TYPE   = TYPE_W'(RST_TYPE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [TYPE_W-1:0] tx_type,
  input  logic [NUM_W-1:0]  tx_num,
  output logic              tx_ready,
  output logic              tx_overflow,
  output logic              tx_timeout,
  output logic              link_busy,
  interboard_link_if.master link,
  output logic              rx_en,
  output logic [TYPE_W-1:0] rx_type,
  output logic [NUM_W-1:0]  rx_num,
  output logic              rx_rst
);

  localparam int MSG_W  = TYPE_W + NUM_W;
  localparam int BEATS  = beats(MSG_W, LINK_W);
  localparam int PAD_W  = BEATS * LINK_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers on the asynchronous handshake inputs. data_in is
  // not synchronised: the peer holds it stable while req is high, and it is
  // only sampled once req_s has settled.
  // ---------------------------------------------------------------------------
  logic req_meta, req_s;
  logic ack_meta, ack_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      req_meta <= link.req_in;
      req_s    <= req_meta;
      ack_meta <= link.ack_in;
      ack_s    <= ack_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [MSG_W-1:0] fifo_data;
  logic [PAD_W-1:0] fifo_padded;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  tx_state_e tx_state;

  // The head entry is consumed the moment the sender leaves IDLE.
  assign fifo_pop    = (tx_state == S_IDLE) && !fifo_empty;
  assign fifo_padded = PAD_W'(fifo_data);

  sync_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_en),
    .wr_data ({tx_type, tx_num}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_ready  = !fifo_full;
  assign link_busy = (tx_state != S_IDLE) || !fifo_empty;

  // A dropped enqueue is judged on the full flag alone, so a pop in the same
  // cycle does not rescue it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_overflow <= 1'b0;
    else      tx_overflow <= tx_en && fifo_full;
  end

  // ---------------------------------------------------------------------------
  // Sender FSM. tx_msg holds the beats not yet placed on data_out; each new
  // beat is shifted out of its low end so beat 0 goes first.
  // ---------------------------------------------------------------------------
  logic [PAD_W-1:0]  tx_msg;
  logic [BEAT_W-1:0] tx_beat;
  logic [CNT_W-1:0]  tx_cnt;
  logic              req_q;
  logic [LINK_W-1:0] data_q;

  assign link.req_out  = req_q;
  assign link.data_out = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state   <= S_IDLE;
      tx_msg     <= '0;
      tx_beat    <= '0;
      tx_cnt     <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      tx_timeout <= 1'b0;
    end else begin
      tx_timeout <= 1'b0;
      case (tx_state)
        S_IDLE: begin
          if (!fifo_empty) begin
            data_q   <= fifo_padded[LINK_W-1:0];
            tx_msg   <= fifo_padded >> LINK_W;
            tx_beat  <= '0;
            tx_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          req_q    <= 1'b1;
          tx_cnt   <= '0;
          tx_state <= S_REQ;
        end
        S_REQ: begin
          if (ack_s) begin
            req_q    <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_REL;
          end else if (tx_cnt == CNT_MAX) begin
            // Peer never answered: drop the rest of this message.
            req_q      <= 1'b0;
            tx_timeout <= 1'b1;
            tx_state   <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        S_REL: begin
          if (!ack_s) begin
            if (tx_beat == LAST_BEAT) begin
              tx_state <= S_IDLE;
            end else begin
              tx_beat  <= tx_beat + BEAT_W'(1);
              data_q   <= tx_msg[LINK_W-1:0];
              tx_msg   <= tx_msg >> LINK_W;
              tx_state <= S_SETUP;
            end
          end else if (tx_cnt == CNT_MAX) begin
            tx_timeout <= 1'b1;
            tx_state   <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM. rx_cnt serves both as the gap timer between beats (R_IDLE
  // with a partial message) and as the stuck-request timer in R_ACK.
  // ---------------------------------------------------------------------------
  rx_state_e         rx_state;
  logic [MSG_W-1:0]  rx_buf;
  logic [BEAT_W-1:0] rx_beat;
  logic [CNT_W-1:0]  rx_cnt;
  logic              ack_q;

  assign link.ack_out = ack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= R_IDLE;
      rx_buf   <= '0;
      rx_beat  <= '0;
      rx_cnt   <= '0;
      ack_q    <= 1'b0;
      rx_en    <= 1'b0;
      rx_rst   <= 1'b0;
      rx_type  <= '0;
      rx_num   <= '0;
    end else begin
      rx_en  <= 1'b0;
      rx_rst <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (req_s) begin
            // Drop the beat into its slot; padding bits above MSG_W are not kept.
            for (int b = 0; b < MSG_W; b++) begin
              if (BEAT_W'(b / LINK_W) == rx_beat) begin
                rx_buf[b] <= link.data_in[b % LINK_W];
              end
            end
            ack_q    <= 1'b1;
            rx_cnt   <= '0;
            rx_state <= R_ACK;
          end else if (rx_beat != '0) begin
            if (rx_cnt == CNT_MAX) begin
              // Peer went silent mid-message: discard the partial message.
              rx_beat <= '0;
              rx_cnt  <= '0;
            end else begin
              rx_cnt <= rx_cnt + CNT_W'(1);
            end
          end else begin
            rx_cnt <= '0;
          end
        end
        R_ACK: begin
          if (!req_s) begin
            ack_q    <= 1'b0;
            rx_cnt   <= '0;
            rx_state <= R_IDLE;
            if (rx_beat == LAST_BEAT) begin
              rx_beat <= '0;
              rx_type <= rx_buf[NUM_W +: TYPE_W];
              rx_num  <= rx_buf[NUM_W-1:0];
              rx_en   <= 1'b1;
              rx_rst  <= (rx_buf[NUM_W +: TYPE_W] == RST_TYPE);
            end else begin
              rx_beat <= rx_beat + BEAT_W'(1);
            end
          end else if (rx_cnt == CNT_MAX) begin
            ack_q    <= 1'b0;
            rx_beat  <= '0;
            rx_cnt   <= '0;
            rx_state <= R_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

endmodule
